// File: rtl/data_sram_slave_pkg.sv
// Shared types and helpers for the CPU data-port SRAM responder.
// Covers the size encodings, the FSM states and the byte-lane decode.
package data_sram_slave_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } state_e;

    // Little-endian lane enables for an access of the given size at byte offset off.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/bytelane_ram.sv
// Word-organised array with per-byte write enables and a registered read port.
// Writes and reads share one enable; a read happens only when no lane is written.
module bytelane_ram #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic [3:0]            we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem [2**ADDR_WIDTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (we_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            if (we_i == 4'b0000) begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_slave.sv
// Slave end of the CPU data-memory interface: accepts one request at a time and
// completes it with a one-cycle data_ok pulse a fixed LATENCY cycles later.
module data_sram_slave
    import data_sram_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        misalign
);

    localparam logic [3:0] LoadCnt = 4'(LATENCY - 1);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  mis_q;
    logic [31:0]           rdata_q;

    logic                  accept;
    logic                  go_resp;
    logic                  acc_wr;
    logic [1:0]            acc_size;
    logic [ADDR_WIDTH+1:0] acc_addr;
    logic [31:0]           acc_wdata;
    logic                  acc_mis;
    logic                  ram_en;
    logic [3:0]            ram_we;
    logic [31:0]           ram_rdata;
    logic [31:0]           resp_word;
    logic                  unused_addr;

    assign unused_addr = ^addr[31:ADDR_WIDTH+2];

    assign addr_ok = (state_q != StBusy);
    assign accept  = req & addr_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_resp = 1'b0;
        unique case (state_q)
            StIdle, StResp: begin
                if (accept) begin
                    cnt_d   = LoadCnt;
                    state_d = (LATENCY > 1) ? StBusy : StResp;
                    go_resp = (LATENCY <= 1);
                end else begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                    go_resp = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // With LATENCY=1 the access happens on the accept edge, so use the live request.
    assign acc_wr    = accept ? wr    : wr_q;
    assign acc_size  = accept ? size  : size_q;
    assign acc_addr  = accept ? addr[ADDR_WIDTH+1:0] : addr_q;
    assign acc_wdata = accept ? wdata : wdata_q;
    assign acc_mis   = misaligned(acc_size, acc_addr[1:0]);

    assign ram_en = go_resp & ~rst;
    assign ram_we = (acc_wr && !acc_mis) ? byte_en(acc_size, acc_addr[1:0]) : 4'b0000;

    bytelane_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk_i  (clk),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .addr_i (acc_addr[ADDR_WIDTH+1:2]),
        .wdata_i(acc_wdata),
        .rdata_o(ram_rdata)
    );

    assign resp_word = mis_q ? 32'd0 : ram_rdata;
    assign data_ok   = (state_q == StResp);
    assign misalign  = data_ok & mis_q;
    assign rdata     = data_ok ? resp_word : rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            mis_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= wr;
                size_q  <= size;
                addr_q  <= addr[ADDR_WIDTH+1:0];
                wdata_q <= wdata;
                mis_q   <= misaligned(size, addr[1:0]);
            end
            if (data_ok) begin
                rdata_q <= resp_word;
            end
        end
    end

endmodule
